// File: rtl/mu_pipe_pkg.sv
// Shared definitions for the mu_pipe neuron-datapath pipeline:
// default sizes and the occupancy-counter update decode.
package mu_pipe_pkg;

   localparam int unsigned MU_DATA_WIDTH = 32;
   localparam int unsigned MU_PIPE_DEPTH = 3;

   typedef enum logic [1:0] {
      OCC_HOLD = 2'd0,
      OCC_INC  = 2'd1,
      OCC_DEC  = 2'd2,
      OCC_CLR  = 2'd3
   } occ_op_e;

   // Flush wins; simultaneous in and out transfers cancel out.
   function automatic occ_op_e occ_op(input logic flush,
                                      input logic in_xfer,
                                      input logic out_xfer);
      if (flush)
         return OCC_CLR;
      else if (in_xfer && !out_xfer)
         return OCC_INC;
      else if (out_xfer && !in_xfer)
         return OCC_DEC;
      else
         return OCC_HOLD;
   endfunction

endpackage

// File: rtl/mu_pipe_stage.sv
// One register stage of mu_pipe: a valid bit plus a WIDTH-bit data word.
// clr empties the stage, ld takes the upstream valid/data, otherwise it holds.
module mu_pipe_stage #(
   parameter int unsigned WIDTH       = 32,
   parameter bit          ZERO_BUBBLE = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             ld,
   input  logic             vld_in,
   input  logic [WIDTH-1:0] dat_in,
   output logic             vld,
   output logic [WIDTH-1:0] dat
);

   logic             vld_q, vld_d;
   logic [WIDTH-1:0] dat_q, dat_d;

   // Next state: clear beats load beats hold; bubbles carry zero data when ZERO_BUBBLE.
   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (clr) begin
         vld_d = 1'b0;
         if (ZERO_BUBBLE)
            dat_d = '0;
      end else if (ld) begin
         vld_d = vld_in;
         dat_d = (ZERO_BUBBLE && !vld_in) ? '0 : dat_in;
      end
   end

   // Stage register; reset clears both valid and data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign vld = vld_q;
   assign dat = dat_q;

endmodule

// File: rtl/mu_pipe.sv
// mu_pipe: DEPTH-stage, LANES-wide register pipeline with valid/ready
// backpressure, bubble collapsing, synchronous flush and an occupancy count.
// Stage 0 is the input side; stage DEPTH-1 drives the outputs directly.
module mu_pipe
   import mu_pipe_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = MU_DATA_WIDTH,
   parameter int unsigned LANES       = 1,
   parameter int unsigned DEPTH       = MU_PIPE_DEPTH,
   parameter bit          ZERO_BUBBLE = 1'b1,
   localparam int unsigned WIDTH      = LANES * DATA_WIDTH,
   localparam int unsigned OCC_W      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_rdy,
   output logic             out_vld,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ack,
   output logic [OCC_W-1:0] occ
);

   if (DEPTH < 1) begin : g_depth_chk
      $error("mu_pipe: DEPTH must be at least 1");
   end

   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] dat [DEPTH];
   logic [DEPTH-1:0] adv;
   logic             in_xfer;
   logic             out_xfer;
   logic [OCC_W-1:0] occ_q, occ_d;

   // A stage may advance when any stage from it to the output is empty or
   // the output is being taken; this is the unrolled form of the ready ripple.
   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic             vld_in_k;
      logic [WIDTH-1:0] dat_in_k;

      if (k == 0) begin : g_head
         assign vld_in_k = in_xfer;
         assign dat_in_k = in_data;
      end else begin : g_body
         assign vld_in_k = vld[k-1];
         assign dat_in_k = dat[k-1];
      end

      assign adv[k] = ~(&vld[DEPTH-1:k]) | out_ack;

      mu_pipe_stage #(
         .WIDTH       (WIDTH),
         .ZERO_BUBBLE (ZERO_BUBBLE)
      ) u_stage (
         .clk    (clk),
         .reset  (reset),
         .clr    (flush),
         .ld     (adv[k]),
         .vld_in (vld_in_k),
         .dat_in (dat_in_k),
         .vld    (vld[k]),
         .dat    (dat[k])
      );
   end

   // Ready is held low during reset and during a flush cycle.
   assign in_rdy   = reset & ~flush & adv[0];
   assign in_xfer  = in_vld & in_rdy;
   assign out_xfer = vld[DEPTH-1] & out_ack;

   // Occupancy next state from the transfer pair.
   always_comb begin
      occ_d = occ_q;
      unique case (occ_op(flush, in_xfer, out_xfer))
         OCC_CLR: occ_d = '0;
         OCC_INC: occ_d = occ_q + 1'b1;
         OCC_DEC: occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   // Occupancy register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         occ_q <= '0;
      else
         occ_q <= occ_d;
   end

   assign out_vld  = vld[DEPTH-1];
   assign out_data = dat[DEPTH-1];
   assign occ      = occ_q;

endmodule

// File: tb/tb_mu_pipe.sv
// Self-checking bench for mu_pipe.
// Instance A: DEPTH=3, LANES=1, ZERO_BUBBLE=1, checked cycle by cycle against
// a conveyor-belt model (queue of beats with stage positions).
// Instance B: DEPTH=1, LANES=4, ZERO_BUBBLE=0, directed lane/stall/reset/flush checks.
module tb_mu_pipe;

   localparam int D = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A
   logic        rst_n, flush, in_vld, out_ack, in_rdy, out_vld;
   logic [31:0] in_data, out_data;
   logic [1:0]  occ;

   mu_pipe #(
      .DATA_WIDTH  (32),
      .LANES       (1),
      .DEPTH       (D),
      .ZERO_BUBBLE (1'b1)
   ) u_dut (
      .clk      (clk),
      .reset    (rst_n),
      .flush    (flush),
      .in_vld   (in_vld),
      .in_data  (in_data),
      .in_rdy   (in_rdy),
      .out_vld  (out_vld),
      .out_data (out_data),
      .out_ack  (out_ack),
      .occ      (occ)
   );

   // Instance B
   logic         b_rst_n, b_flush, b_in_vld, b_out_ack, b_in_rdy, b_out_vld;
   logic [127:0] b_in_data, b_out_data;
   logic [0:0]   b_occ;

   mu_pipe #(
      .DATA_WIDTH  (32),
      .LANES       (4),
      .DEPTH       (1),
      .ZERO_BUBBLE (1'b0)
   ) u_dut_b (
      .clk      (clk),
      .reset    (b_rst_n),
      .flush    (b_flush),
      .in_vld   (b_in_vld),
      .in_data  (b_in_data),
      .in_rdy   (b_in_rdy),
      .out_vld  (b_out_vld),
      .out_data (b_out_data),
      .out_ack  (b_out_ack),
      .occ      (b_occ)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: beats in flight, oldest first, each with its stage index.
   typedef struct {
      logic [31:0] d;
      int          pos;
   } beat_t;

   beat_t mq[$];

   // One cycle on instance A: drive, check against model, clock, advance model.
   task automatic step(input logic v, input logic [31:0] d, input logic a, input logic f);
      beat_t       nq[$];
      beat_t       b;
      int          lim;
      int          np;
      logic        rdy;
      logic        exp_vld;
      logic [31:0] exp_dat;

      in_vld  = v;
      in_data = d;
      out_ack = a;
      flush   = f;
      #1;
      rdy     = !f && ((mq.size() < D) || a);
      exp_vld = (mq.size() > 0) && (mq[0].pos == D - 1);
      exp_dat = exp_vld ? mq[0].d : 32'h0;
      chk("in_rdy",   in_rdy,   rdy);
      chk("out_vld",  out_vld,  exp_vld);
      chk("out_data", out_data, exp_dat);
      chk("occ",      occ,      mq.size());

      if (!f) begin
         lim = D - 1;
         foreach (mq[i]) begin
            if (i == 0 && mq[i].pos == D - 1 && a)
               continue;
            np    = (mq[i].pos + 1 < lim) ? mq[i].pos + 1 : lim;
            b.d   = mq[i].d;
            b.pos = np;
            nq.push_back(b);
            lim = np - 1;
         end
         if (v && rdy) begin
            b.d   = d;
            b.pos = 0;
            nq.push_back(b);
         end
      end

      @(posedge clk);
      mq = nq;
      #1;
   endtask

   initial begin
      // Reset held with a beat offered on both instances
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_vld    = 1'b1;
      in_data   = 32'hA5A5A5A5;
      out_ack   = 1'b0;
      b_rst_n   = 1'b0;
      b_flush   = 1'b0;
      b_in_vld  = 1'b1;
      b_in_data = {4{32'hA5A5A5A5}};
      b_out_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_vld",  out_vld,  1'b0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_occ",      occ,      2'd0);
      chk("rst_in_rdy",   in_rdy,   1'b0);
      chk("b_rst_in_rdy", b_in_rdy, 1'b0);
      chk("b_rst_occ",    b_occ,    1'b0);

      @(negedge clk);
      in_vld   = 1'b0;
      b_in_vld = 1'b0;
      rst_n    = 1'b1;
      b_rst_n  = 1'b1;
      #1;
      chk("rel_in_rdy",   in_rdy,   1'b1);
      chk("b_rel_in_rdy", b_in_rdy, 1'b1);
      mq.delete();

      // Streaming with out_ack held high
      for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b1, 1'b0);
      repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);

      // Stall until full, then release one beat
      for (int i = 1; i <= 5; i++) step(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
      step(1'b1, 32'h20, 1'b1, 1'b0);
      repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0);

      // Flush a full pipe with input and ack both offered
      step(1'b1, 32'hFF, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0);

      // Bubble collapse behind a stalled output
      step(1'b1, 32'h41, 1'b0, 1'b0);
      step(1'b0, 32'h0,  1'b0, 1'b0);
      step(1'b1, 32'h42, 1'b0, 1'b0);
      repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b1);

      // Randomized traffic with occasional flushes
      repeat (400)
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
              $urandom_range(0, 24) == 0);

      // Asynchronous reset while holding beats
      repeat (3) step(1'b1, $urandom, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_vld",  out_vld,  1'b0);
      chk("mid_rst_out_data", out_data, 32'h0);
      chk("mid_rst_occ",      occ,      2'd0);
      chk("mid_rst_in_rdy",   in_rdy,   1'b0);
      mq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 32'h77, 1'b1, 1'b0);
      repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);
      in_vld = 1'b0;
      flush  = 1'b0;

      // Instance B: four lanes, single stage
      for (int i = 0; i < 4; i++) b_in_data[i*32 +: 32] = 32'h100 + 32'(i);
      b_in_vld  = 1'b1;
      b_out_ack = 1'b1;
      #1;
      chk("b_in_rdy_empty", b_in_rdy, 1'b1);
      @(posedge clk);
      #1;
      chk("b_out_vld", b_out_vld, 1'b1);
      chk("b_occ",     b_occ,     1'b1);
      for (int i = 0; i < 4; i++) chk("b_lane", b_out_data[i*32 +: 32], 32'h100 + 32'(i));

      // Stall: full stage, no ack
      b_out_ack = 1'b0;
      for (int i = 0; i < 4; i++) b_in_data[i*32 +: 32] = 32'h200 + 32'(i);
      #1;
      chk("b_in_rdy_full", b_in_rdy, 1'b0);
      @(posedge clk);
      #1;
      chk("b_frozen_lane0", b_out_data[31:0], 32'h100);
      chk("b_frozen_occ",   b_occ,            1'b1);

      // Reset mid-stall clears at once
      b_rst_n = 1'b0;
      #1;
      chk("b_mid_rst_vld",  b_out_vld, 1'b0);
      chk("b_mid_rst_occ",  b_occ,     1'b0);
      chk("b_mid_rst_data", b_out_data[63:0], 64'h0);
      chk("b_mid_rst_data_hi", b_out_data[127:64], 64'h0);
      @(negedge clk);
      b_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) b_in_data[i*32 +: 32] = 32'h300 + 32'(i);
      @(posedge clk);
      #1;
      chk("b_post_rst_vld",   b_out_vld,        1'b1);
      chk("b_post_rst_lane0", b_out_data[31:0], 32'h300);

      // Flush with ZERO_BUBBLE=0: valid drops, data holds, input dropped
      b_flush   = 1'b1;
      b_out_ack = 1'b1;
      for (int i = 0; i < 4; i++) b_in_data[i*32 +: 32] = 32'h400 + 32'(i);
      #1;
      chk("b_flush_in_rdy", b_in_rdy, 1'b0);
      @(posedge clk);
      #1;
      chk("b_flush_vld", b_out_vld, 1'b0);
      chk("b_flush_occ", b_occ,     1'b0);
      for (int i = 0; i < 4; i++) chk("b_flush_hold", b_out_data[i*32 +: 32], 32'h300 + 32'(i));
      b_flush  = 1'b0;
      b_in_vld = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
